crc_frame_sequencer: RTL and testbench
======================================

// Module: crc_frame_sequencer
// PURPOSE
//  Per-frame CRC-8 sequencer for the ETROC2 readout word stream (40-bit header/data/trailer/filler).
//  Owns the running CRC register and drives one combinational CRC8 instance (poly x^8+x^5+x^3+x^2+x+1, MSB-first).
//  Seeds the CRC at the header, accumulates over data words, and writes the result into trailer bits [7:0].
//  Sits between frame builder and serializer; 1-cycle latency with valid/ready backpressure.
// PARAMETERS
//  WORDWIDTH  40  word width; the CRC field is always bits [7:0] of the trailer
//  CRCINIT    8'h00  CRC seed loaded at each header
//  CNTWIDTH   16  width of frame_cnt
// PORTS
//  clk        in   1          readout clock; only clock
//  reset      in   1          synchronous, active-high
//  crc_en     in   1          1: insert CRC into trailer; sampled only when a header is accepted
//  in_valid   in   1          input word valid
//  in_ready   out  1          input accepted when in_valid&&in_ready
//  in_type    in   2          0 filler, 1 header, 2 data, 3 trailer
//  in_data    in   WORDWIDTH  input word
//  out_valid  out  1          output word valid
//  out_ready  in   1          downstream accept
//  out_type   out  2          type of out_data (copied from input)
//  out_data   out  WORDWIDTH  output word; trailer CRC field patched
//  out_crc    out  8          CRC of the last completed frame
//  frame_done out  1          1-cycle pulse when a trailer is accepted in IN_FRAME
//  err_seq    out  1          1-cycle pulse on a framing violation
//  frame_cnt  out  CNTWIDTH   completed frames, wraps at 2^CNTWIDTH-1 -> 0
// BEHAVIOUR
//  Reset: all outputs, crc_reg, and the latched crc_en are 0; state=IDLE; in_ready=1 in the cycle after reset.
//  Reset mid-frame: the partial frame is dropped and any pending out word is discarded; no err_seq.
//  in_ready = !out_valid || out_ready (single output register, no skid); on a hold, out_* are unchanged.
//  Accepted word -> out_valid=1 with that word on the next cycle. out_valid clears when out_ready=1 and no new word is accepted.
//  FSM IDLE/IN_FRAME, advancing only on accepted words:
//   IDLE  + header  -> IN_FRAME; crc_reg=CRC8(CRCINIT,hdr); en_l=crc_en
//   IDLE  + data/trailer -> pass unchanged, err_seq; stay in IDLE
//   IN_FRAME + data -> crc_reg=CRC8(crc_reg,data)
//   IN_FRAME + header -> err_seq; restart: crc_reg=CRC8(CRCINIT,hdr), re-latch en_l
//   IN_FRAME + trailer -> c=CRC8(crc_reg,{trl[W-1:8],8'h00})
//     out_data={trl[W-1:8], en_l?c:trl[7:0]}; out_crc=c; frame_done; frame_cnt++; ->IDLE
//   filler, any state -> pass unchanged; crc_reg and state hold (dis input tied 0)
//  out_crc, frame_cnt, and frame_done update in the same cycle out_valid rises for the trailer.
//  A crc_en change mid-frame takes effect at the next header only.
// STRUCTURE
//  Shared package etroc2_readout_pkg: word type codes (FILLER/HEADER/DATA/TRAILER), CRC_W=8, CRC_LSB=0.
//  One CRC8 instance (WORDWIDTH), with cin muxed: CRCINIT on header, else crc_reg.
//  din muxed: trailer has its low byte zeroed.
//  Sequencer FSM, output register, and counters live in this module; no further sub-modules.
// TESTING
//  1 hdr 40'h0, trl 40'h00_0000_0100, crc_en=1 -> out trl 40'h00_0000_01E9, out_crc=8'hE9, frame_done, frame_cnt=1
//  2 hdr 40'h0, data 40'h1, trl 40'h0 -> after data crc_reg=8'h2F; trailer CRC matches the bitwise software model
//  3 same as 1 with crc_en=0 at the header (toggled to 1 mid-frame) -> trl out 40'h00_0000_0100, out_crc=8'hE9
//  4 out_ready=0 for 5 cycles mid-frame -> in_ready=0, out_data stable, no word lost/duplicated, CRC unchanged
//  5 filler words between data -> fillers passed unchanged; trailer CRC identical to the filler-free frame
//  6 data in IDLE, second header in a frame, reset mid-frame -> err_seq pulses (not on reset); new frame CRC correct

Source files
------------

// File: rtl/etroc2_readout_pkg.sv
// Shared definitions for the ETROC2 readout word stream: word type codes,
// CRC field placement, CRC-8 polynomial and the frame sequencer states.
package etroc2_readout_pkg;

    typedef enum logic [1:0] {
        FILLER  = 2'd0,
        HEADER  = 2'd1,
        DATA    = 2'd2,
        TRAILER = 2'd3
    } word_type_e;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } seq_state_e;

    localparam int CRC_W   = 8;
    localparam int CRC_LSB = 0;

    // x^8 + x^5 + x^3 + x^2 + x + 1, implicit x^8 term dropped
    localparam logic [CRC_W-1:0] CRC_POLY = 8'h2F;

endpackage

// File: rtl/crc_frame_sequencer_crc8.sv
// Combinational CRC-8 over one full word, MSB first, continuing from cin.
// With dis asserted the incoming CRC is passed through untouched.
module crc_frame_sequencer_crc8
    import etroc2_readout_pkg::*;
#(
    parameter int WORDWIDTH = 40
) (
    input  logic [CRC_W-1:0]     cin,
    input  logic [WORDWIDTH-1:0] din,
    input  logic                 dis,
    output logic [CRC_W-1:0]     cout
);

    logic [CRC_W-1:0] crc_v;
    logic             fb;

    always_comb begin
        crc_v = cin;
        fb    = 1'b0;
        for (int i = WORDWIDTH - 1; i >= 0; i--) begin
            fb    = crc_v[CRC_W-1] ^ din[i];
            crc_v = {crc_v[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        cout = dis ? cin : crc_v;
    end

endmodule

// File: rtl/crc_frame_sequencer.sv
// Per-frame CRC-8 sequencer: seeds at the header, accumulates over data words
// and patches the CRC into the trailer low byte, behind a single output register.
module crc_frame_sequencer
    import etroc2_readout_pkg::*;
#(
    parameter int               WORDWIDTH = 40,
    parameter logic [CRC_W-1:0] CRCINIT   = 8'h00,
    parameter int               CNTWIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 crc_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_type,
    input  logic [WORDWIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_type,
    output logic [WORDWIDTH-1:0] out_data,
    output logic [CRC_W-1:0]     out_crc,
    output logic                 frame_done,
    output logic                 err_seq,
    output logic [CNTWIDTH-1:0]  frame_cnt
);

    seq_state_e             state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [1:0]             out_type_q, out_type_d;
    logic [WORDWIDTH-1:0]   out_data_q, out_data_d;
    logic [CRC_W-1:0]       out_crc_q, out_crc_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_seq_q, err_seq_d;
    logic [CNTWIDTH-1:0]    frame_cnt_q, frame_cnt_d;
    logic [CRC_W-1:0]       crc_reg_q, crc_reg_d;
    logic                   en_l_q, en_l_d;

    word_type_e             in_type_e;
    logic                   accept;
    logic [CRC_W-1:0]       crc_cin;
    logic [WORDWIDTH-1:0]   crc_din;
    logic [CRC_W-1:0]       crc_out;

    assign in_type_e = word_type_e'(in_type);
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;

    // The trailer's own CRC field is treated as zero while it is being covered.
    assign crc_cin = (in_type_e == HEADER) ? CRCINIT : crc_reg_q;
    assign crc_din = (in_type_e == TRAILER)
                   ? {in_data[WORDWIDTH-1:CRC_LSB+CRC_W], {CRC_W{1'b0}}}
                   : in_data;

    crc_frame_sequencer_crc8 #(
        .WORDWIDTH (WORDWIDTH)
    ) u_crc8 (
        .cin  (crc_cin),
        .din  (crc_din),
        .dis  (1'b0),
        .cout (crc_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (in_type_e)
                HEADER:  state_d = IN_FRAME;
                TRAILER: state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_type_d   = out_type_q;
        out_data_d   = out_data_q;
        out_crc_d    = out_crc_q;
        frame_cnt_d  = frame_cnt_q;
        crc_reg_d    = crc_reg_q;
        en_l_d       = en_l_q;
        frame_done_d = 1'b0;
        err_seq_d    = 1'b0;
        if (accept) begin
            out_valid_d = 1'b1;
            out_type_d  = in_type;
            out_data_d  = in_data;
            case (in_type_e)
                HEADER: begin
                    crc_reg_d = crc_out;
                    en_l_d    = crc_en;
                    err_seq_d = (state_q == IN_FRAME);
                end
                DATA: begin
                    if (state_q == IN_FRAME) begin
                        crc_reg_d = crc_out;
                    end else begin
                        err_seq_d = 1'b1;
                    end
                end
                TRAILER: begin
                    if (state_q == IN_FRAME) begin
                        if (en_l_q) begin
                            out_data_d[CRC_LSB +: CRC_W] = crc_out;
                        end
                        out_crc_d    = crc_out;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + CNTWIDTH'(1);
                    end else begin
                        err_seq_d = 1'b1;
                    end
                end
                default: begin
                    crc_reg_d = crc_reg_q;
                end
            endcase
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_type_q   <= '0;
            out_data_q   <= '0;
            out_crc_q    <= '0;
            frame_done_q <= 1'b0;
            err_seq_q    <= 1'b0;
            frame_cnt_q  <= '0;
            crc_reg_q    <= '0;
            en_l_q       <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_type_q   <= out_type_d;
            out_data_q   <= out_data_d;
            out_crc_q    <= out_crc_d;
            frame_done_q <= frame_done_d;
            err_seq_q    <= err_seq_d;
            frame_cnt_q  <= frame_cnt_d;
            crc_reg_q    <= crc_reg_d;
            en_l_q       <= en_l_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_type   = out_type_q;
    assign out_data   = out_data_q;
    assign out_crc    = out_crc_q;
    assign frame_done = frame_done_q;
    assign err_seq    = err_seq_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_crc_frame_sequencer.sv
// Bench for crc_frame_sequencer: directed frames plus randomized traffic, checked
// against a frame-level reference that computes the CRC by polynomial long division.
module tb_crc_frame_sequencer;
    import etroc2_readout_pkg::*;

    localparam int W  = 40;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          crc_en = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [1:0]    in_type = 2'd0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [1:0]    out_type;
    logic [W-1:0]  out_data;
    logic [7:0]    out_crc;
    logic          frame_done;
    logic          err_seq;
    logic [CW-1:0] frame_cnt;

    int checks = 0;
    int failures = 0;

    // Reference state: the frame is kept as a plain bit string since its header.
    bit            m_in_frame;
    bit            m_en_l;
    bit            m_bits[$];
    logic [7:0]    m_out_crc;
    logic [CW-1:0] m_cnt;
    logic          m_ov;
    logic [1:0]    m_ot;
    logic [W-1:0]  m_od;
    logic          m_done;
    logic          m_err;

    crc_frame_sequencer #(
        .WORDWIDTH (W),
        .CRCINIT   (8'h00),
        .CNTWIDTH  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .crc_en     (crc_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_type   (out_type),
        .out_data   (out_data),
        .out_crc    (out_crc),
        .frame_done (frame_done),
        .err_seq    (err_seq),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Remainder of M(x)*x^8 divided by the generator, done as long division.
    function automatic logic [7:0] refCrc(input bit bits[$]);
        bit         d[$];
        logic [8:0] gen;
        logic [7:0] r;
        gen = 9'h12F;
        d = bits;
        for (int k = 0; k < 8; k++) d.push_back(1'b0);
        for (int i = 0; i + 8 < d.size(); i++) begin
            if (d[i]) begin
                for (int j = 0; j < 9; j++) d[i+j] = d[i+j] ^ gen[8-j];
            end
        end
        r = '0;
        for (int k = 0; k < 8; k++) r[7-k] = d[d.size()-8+k];
        return r;
    endfunction

    function automatic logic [W-1:0] rand40();
        return W'({$urandom(), $urandom()});
    endfunction

    task automatic appendWord(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) m_bits.push_back(w[i]);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_in_frame = 1'b0;
        m_en_l     = 1'b0;
        m_bits.delete();
        m_out_crc  = '0;
        m_cnt      = '0;
        m_ov       = 1'b0;
        m_ot       = '0;
        m_od       = '0;
        m_done     = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic modelStep(input logic acc, input logic [1:0] t, input logic [W-1:0] d,
                             input logic en, input logic rdy);
        logic [7:0] c;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (acc) begin
            m_ov = 1'b1;
            m_ot = t;
            m_od = d;
            case (t)
                HEADER: begin
                    if (m_in_frame) m_err = 1'b1;
                    m_in_frame = 1'b1;
                    m_en_l     = en;
                    m_bits.delete();
                    appendWord(d);
                end
                DATA: begin
                    if (m_in_frame) appendWord(d);
                    else m_err = 1'b1;
                end
                TRAILER: begin
                    if (m_in_frame) begin
                        appendWord({d[W-1:8], 8'h00});
                        c = refCrc(m_bits);
                        if (m_en_l) m_od[7:0] = c;
                        m_out_crc  = c;
                        m_done     = 1'b1;
                        m_cnt      = m_cnt + 1'b1;
                        m_in_frame = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (rdy) begin
            m_ov = 1'b0;
        end
    endtask

    // One clock of stimulus, followed by a full comparison of the DUT outputs.
    task automatic applyStimulus(input logic v, input logic [1:0] t, input logic [W-1:0] d,
                                 input logic en, input logic rdy, output logic acc);
        logic exp_rdy;
        in_valid  = v;
        in_type   = t;
        in_data   = d;
        crc_en    = en;
        out_ready = rdy;
        #1;
        exp_rdy = !m_ov || rdy;
        checkOutput("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        modelStep(acc, t, d, en, rdy);
        checkOutput("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            checkOutput("out_type", 64'(out_type), 64'(m_ot));
            checkOutput("out_data", 64'(out_data), 64'(m_od));
        end
        checkOutput("out_crc", 64'(out_crc), 64'(m_out_crc));
        checkOutput("frame_done", 64'(frame_done), 64'(m_done));
        checkOutput("err_seq", 64'(err_seq), 64'(m_err));
        checkOutput("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    endtask

    task automatic sendWord(input logic [1:0] t, input logic [W-1:0] d, input logic en, input int stall);
        logic acc;
        logic rdy;
        acc = 1'b0;
        for (int k = 0; k < 64; k++) begin
            rdy = (k < stall) ? 1'b0 : ($urandom_range(0, 3) != 0);
            applyStimulus(1'b1, t, d, en, rdy, acc);
            if (acc) break;
        end
        checkOutput("send_accept", 64'(acc), 64'(1));
    endtask

    task automatic idleCycles(input int n);
        logic acc;
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, FILLER, '0, crc_en, 1'($urandom_range(0, 1)), acc);
        end
    endtask

    task automatic doReset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("rst_err_seq", 64'(err_seq), 64'(0));
            checkOutput("rst_frame_done", 64'(frame_done), 64'(0));
        end
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_crc", 64'(out_crc), 64'(0));
        checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    endtask

    initial begin
        logic          en;
        int            n;
        logic [W-1:0]  w;

        modelReset();
        doReset();

        $display("[TB] directed frame with CRC insertion");
        sendWord(HEADER, 40'h0, 1'b1, 0);
        sendWord(TRAILER, 40'h00_0000_0100, 1'b1, 0);
        checkOutput("t1_trl_data", 64'(out_data), 64'(40'h00_0000_01E9));
        checkOutput("t1_out_crc", 64'(out_crc), 64'(8'hE9));
        checkOutput("t1_frame_cnt", 64'(frame_cnt), 64'(1));
        idleCycles(2);

        $display("[TB] single data word frame");
        sendWord(HEADER, 40'h0, 1'b1, 0);
        sendWord(DATA, 40'h1, 1'b1, 0);
        sendWord(TRAILER, 40'h0, 1'b1, 0);
        idleCycles(1);

        $display("[TB] crc_en latched at header only");
        sendWord(HEADER, 40'h0, 1'b0, 0);
        sendWord(TRAILER, 40'h00_0000_0100, 1'b1, 0);
        checkOutput("t3_trl_data", 64'(out_data), 64'(40'h00_0000_0100));
        checkOutput("t3_out_crc", 64'(out_crc), 64'(8'hE9));
        idleCycles(1);

        $display("[TB] backpressure mid-frame");
        sendWord(HEADER, 40'hA5_1234_5678, 1'b1, 0);
        sendWord(DATA, 40'h01_0203_0405, 1'b1, 0);
        sendWord(DATA, 40'hFF_EEDD_CCBB, 1'b1, 5);
        sendWord(TRAILER, 40'h77_6655_4433, 1'b1, 3);
        idleCycles(2);

        $display("[TB] fillers inside a frame");
        sendWord(HEADER, 40'h12_3456_789A, 1'b1, 0);
        sendWord(DATA, 40'h00_DEAD_BEEF, 1'b1, 0);
        sendWord(FILLER, 40'h3C_3C3C_3C3C, 1'b1, 0);
        sendWord(DATA, 40'h80_0000_0001, 1'b1, 0);
        sendWord(FILLER, 40'h3C_3C3C_3C3C, 1'b1, 0);
        sendWord(TRAILER, 40'h55_AA55_AA00, 1'b1, 0);
        idleCycles(1);

        $display("[TB] framing violations and reset mid-frame");
        sendWord(DATA, 40'h11_1111_1111, 1'b1, 0);
        sendWord(TRAILER, 40'h22_2222_2222, 1'b1, 0);
        sendWord(HEADER, 40'h33_3333_3333, 1'b1, 0);
        sendWord(DATA, 40'h44_4444_4444, 1'b1, 0);
        sendWord(HEADER, 40'h55_5555_5555, 1'b0, 0);
        sendWord(DATA, 40'h66_6666_6666, 1'b1, 0);
        sendWord(TRAILER, 40'h77_7777_7777, 1'b1, 0);
        sendWord(HEADER, 40'h88_8888_8888, 1'b1, 0);
        sendWord(DATA, 40'h99_9999_9999, 1'b1, 0);
        doReset();
        sendWord(TRAILER, 40'hAA_AAAA_AAAA, 1'b1, 0);
        sendWord(HEADER, 40'hBB_BBBB_BBBB, 1'b1, 0);
        sendWord(DATA, 40'hCC_CCCC_CCCC, 1'b1, 0);
        sendWord(TRAILER, 40'hDD_DDDD_DDDD, 1'b1, 0);
        idleCycles(2);

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) sendWord(DATA, rand40(), en, 0);
            sendWord(HEADER, rand40(), en, $urandom_range(0, 2));
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 2) == 0) sendWord(FILLER, rand40(), 1'($urandom_range(0, 1)), 0);
                if ($urandom_range(0, 11) == 0) sendWord(HEADER, rand40(), 1'($urandom_range(0, 1)), 0);
                w = rand40();
                sendWord(DATA, w, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
            sendWord(TRAILER, rand40(), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            idleCycles($urandom_range(0, 2));
        end
        idleCycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
